instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the core datapath.
- Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents the head entry (Instr plus PC) to decode/datapath.
- Accepts branch/jump redirects from the datapath, flushes wrong-path instructions, and discards in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and max outstanding requests (power of two, >=2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr_data when the queue is empty

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response data valid; responses in request order, latency >=1 cycle
- imem_rsp_data  input  32  returned instruction word
- instr_valid  output  1  head entry valid
- instr_ready  input  1  downstream consumes head
- instr_data  output  32  head instruction (Instr to datapath)
- instr_pc  output  32  PC of head instruction
- redirect_valid  input  1  taken branch/jump from datapath (PCSrc)
- redirect_pc  input  32  redirect target
- queue_count  output  clog2(DEPTH)+1  occupied entries (debug/perf)

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=RUN.
  - Outputs: imem_req_valid=0, instr_valid=0, instr_data=NOP_INSTR, instr_pc=0, queue_count=0.
  - imem_req_valid may assert in the first clk edge cycle after release.
- Request issue (RUN only):
  - imem_req_valid=1 iff queue_count+outstanding < DEPTH.
  - imem_req_addr=fetch_pc.
  - On handshake (valid&ready): fetch_pc += 4, outstanding += 1.
  - Address wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - imem_req_valid, once high, stays high with a stable address until accepted, unless a redirect occurs.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise push {pc, data}; the pc is tracked by a parallel PC FIFO or an issue-PC counter.
  - Credit rule guarantees no push into a full FIFO; overflow is an assertion failure.
- Output:
  - Head visible combinationally: instr_valid = (queue_count != 0).
  - Pop on instr_valid & instr_ready.
  - When empty: instr_data=NOP_INSTR, instr_pc=last pc.
  - Latency: response at edge N, head valid after edge N (1-cycle fill latency); full throughput of 1 instr/cycle with 1-cycle memory.
- Redirect (redirect_valid=1 at an edge, either state):
  - FIFO cleared.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding after this cycle's handshake/response updates: a request accepted the same cycle is counted; a response arriving the same cycle is dropped.
  - Next state = DRAIN if that discard>0, else RUN.
  - A pop in the same cycle is ignored (flush wins).
  - imem_req_valid is forced 0 in the redirect cycle.
- DRAIN: no requests issued; move to RUN on the edge where discard reaches 0. A further redirect in DRAIN updates fetch_pc only.
- Simultaneous push and pop: queue_count unchanged.
- Simultaneous push into the last free slot and request attempt: the credit rule alone decides; no combinational path from instr_ready to imem_req_valid.
- Pointers wrap modulo DEPTH; count saturates-checked 0..DEPTH.

Test Plan:
1. Assert reset 3 cycles mid-fetch with 2 outstanding -> all outputs at reset values immediately (async). After release, first imem_req_addr=0x0, and stale responses arriving afterward are not accepted (bench holds rsp low).
2. 1-cycle memory, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8,0xC... one per cycle after 2-cycle startup; instr_data matches memory image.
3. instr_ready=0, memory always ready -> exactly 4 requests (0x0..0xC), then imem_req_valid=0 and queue_count=4. Release ready -> requests resume at 0x10.
4. 3-cycle memory latency, 2 outstanding, redirect_pc=0x103 -> queue flushed, next request addr=0x100 only after both stale responses are dropped. First delivered instr_pc=0x100.
5. Redirect in the same cycle as a response and a pop -> response dropped, instr_valid=0 next cycle, queue_count=0, no extra pop.
6. Redirect to 0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
//
// Bundles every handshake/bus signal of the fetch queue so the fetch unit and
// its surroundings (instruction memory, decode, branch resolution) connect
// through one port.
//
//   imem_req_valid / imem_req_ready / imem_req_addr : word fetch request
//   imem_rsp_valid / imem_rsp_data                  : in-order fetch response
//   instr_valid / instr_ready / instr_data / instr_pc : head entry to decode
//   redirect_valid / redirect_pc                    : taken branch / jump
//   queue_count                                     : occupied entries
//
// Modports:
//   master : the fetch queue itself
//   slave  : memory + datapath side
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [31:0]   instr_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] queue_count;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    output queue_count
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    input  queue_count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage in front of the core datapath. Owns the fetch PC, issues
// in-order word requests to instruction memory, buffers the returned words
// together with their PCs in a DEPTH-entry FIFO and presents the head entry
// to decode. Taken branches/jumps flush the FIFO and every response still in
// flight is discarded before fetching resumes at the new target.
//
// Ports:
//   clk    : core clock, all state on the rising edge
//   reset  : asynchronous, active-low reset
//   bus    : instr_fetch_queue_if.master (memory request/response,
//            instruction output, redirect input, queue_count)
//
// Parameters:
//   DEPTH     : FIFO entries and maximum outstanding requests (power of two)
//   RESET_PC  : first fetch address after reset
//   NOP_INSTR : word shown on instr_data while the queue is empty
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = (CW+1)'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Control state
  logic [0:0]    state_q,    state_d;
  logic          started_q,  started_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q,   rsp_pc_d;
  logic [31:0]   last_pc_q,  last_pc_d;
  logic [CW-1:0] out_q,      out_d;
  logic [CW-1:0] disc_q,     disc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;

  // FIFO storage; contents are only observed through count_q, so no reset
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          req_valid;
  logic          req_hs;
  logic          head_valid;
  logic          push;
  logic          pop;
  logic          redirect;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] out_after;

  assign redirect     = bus.redirect_valid;
  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

  // Credit rule: every outstanding request owns a FIFO slot, so a response
  // can always be pushed. Built only from registered state so there is no
  // combinational path from instr_ready to imem_req_valid.
  assign credit_sum = {1'b0, count_q} + {1'b0, out_q};
  assign credit_ok  = credit_sum < DEPTH_C1;

  // started_q keeps the request line low until the first edge after reset.
  assign req_valid  = started_q && (state_q == ST_RUN) && !redirect && credit_ok;
  assign req_hs     = req_valid && bus.imem_req_ready;

  assign head_valid = (count_q != '0);

  // A flush wins over both the pop and the push of the same cycle.
  assign pop  = head_valid && bus.instr_ready && !redirect;
  assign push = bus.imem_rsp_valid && (disc_q == '0) && !redirect;

  // Outstanding count after this cycle's request and response
  assign out_after = out_q + CW'(req_hs) - CW'(bus.imem_rsp_valid);

  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    last_pc_d  = last_pc_q;
    out_d      = out_after;
    disc_d     = disc_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (req_hs) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (bus.imem_rsp_valid && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end

    // rsp_pc_q is the PC of the next response that will be kept
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

    if (pop) begin
      last_pc_d = fifo_pc_q[rd_ptr_q];
    end

    if ((state_q == ST_DRAIN) && (disc_d == '0)) begin
      state_d = ST_RUN;
    end

    // Every request still in flight after this edge belongs to the wrong
    // path; remember how many to drop before fetching resumes.
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      disc_d     = out_after;
      state_d    = (out_after != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      started_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      last_pc_q  <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      last_pc_q  <= last_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr_data     = head_valid ? fifo_data_q[rd_ptr_q] : NOP_INSTR;
  assign bus.instr_pc       = head_valid ? fifo_pc_q[rd_ptr_q]   : last_pc_q;
  assign bus.queue_count    = count_q;

  // The credit rule must make FIFO overflow and stray responses impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_q == DEPTH_C)));

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    !(bus.imem_rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0E};
  endfunction

  // ---------------- bench memory and observed event logs ----------------
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] pop_pc[$];
  int          cyc = 0;

  // ---------------- reference model ----------------
  // Issued requests are kept in order; a redirect marks all of them stale.
  typedef struct {logic [31:0] pc; bit stale;} iss_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  iss_t        m_iss[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_last_pc;
  bit          m_started;

  // knobs
  int          p_rdy = 100, p_ird = 100, p_redir = 0, p_rsp = 100, lat = 1;
  bit          do_redir = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic bit m_drain();
    foreach (m_iss[i]) if (m_iss[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_req_valid();
    return m_started && !m_drain() && !bus.redirect_valid &&
           ((m_fifo.size() + m_iss.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic model_clear();
    m_iss.delete();
    m_fifo.delete();
    mem_q.delete();
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    m_fetch_pc = 32'h0;
    m_last_pc  = 32'h0;
    m_started  = 1'b0;
  endtask

  task automatic model_step(input bit exp_rv);
    iss_t e;
    bit   got;
    int   pre;
    got = 1'b0;
    if (exp_rv && bus.imem_req_ready) begin
      m_iss.push_back('{m_fetch_pc, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (bus.imem_rsp_valid && m_iss.size() > 0) begin
      e   = m_iss.pop_front();
      got = 1'b1;
    end
    if (bus.redirect_valid) begin
      m_fifo.delete();
      foreach (m_iss[i]) m_iss[i].stale = 1'b1;
      m_fetch_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      pre = m_fifo.size();
      if (got && !e.stale) m_fifo.push_back('{e.pc, memword(e.pc)});
      if (pre > 0 && bus.instr_ready) begin
        m_last_pc = m_fifo[0].pc;
        void'(m_fifo.pop_front());
      end
    end
    m_started = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    bit          exp_rv, rsp_take;
    logic        a_rv, a_iv;
    logic [31:0] a_addr, a_ipc;
    int          l;
    @(negedge clk);
    bus.imem_req_ready = ($urandom_range(99) < p_rdy);
    rsp_take = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(mem_q[0].addr);
      rsp_take = 1'b1;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.instr_ready = ($urandom_range(99) < p_ird);
    if (do_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_target;
      do_redir = 1'b0;
    end else begin
      bus.redirect_valid = ($urandom_range(99) < p_redir);
      bus.redirect_pc    = $urandom;
    end
    #1;
    exp_rv = m_req_valid();
    check("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", bus.imem_req_addr, m_fetch_pc);
    check("instr_valid", bus.instr_valid, m_fifo.size() != 0);
    check("instr_data", bus.instr_data, (m_fifo.size() != 0) ? m_fifo[0].data : NOP);
    check("instr_pc", bus.instr_pc, (m_fifo.size() != 0) ? m_fifo[0].pc : m_last_pc);
    check("queue_count", bus.queue_count, m_fifo.size());
    a_rv   = bus.imem_req_valid;
    a_addr = bus.imem_req_addr;
    a_iv   = bus.instr_valid;
    a_ipc  = bus.instr_pc;
    @(posedge clk);
    if (rsp_take) void'(mem_q.pop_front());
    if (a_rv && bus.imem_req_ready) begin
      l = (lat > 0) ? lat : int'($urandom_range(4, 1));
      mem_q.push_back('{a_addr, cyc + l});
      acc_addr.push_back(a_addr);
      acc_cyc.push_back(cyc);
    end
    if (a_iv && bus.instr_ready && !bus.redirect_valid) pop_pc.push_back(a_ipc);
    model_step(exp_rv);
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, holds 3 cycles.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req_valid",   bus.imem_req_valid, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instr_data",  bus.instr_data, NOP);
    check("rst_instr_pc",    bus.instr_pc, 32'h0);
    check("rst_queue_count", bus.queue_count, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int n, k, rc;
    idle_inputs();
    do_reset();

    // 1: reset mid-fetch with two requests outstanding
    p_rdy = 100; p_ird = 0; p_rsp = 100; p_redir = 0; lat = 4;
    for (k = 0; k < 30 && m_iss.size() < 2; k++) step();
    check("t1_two_outstanding", m_iss.size() >= 2, 1'b1);
    do_reset();

    // 2: 1-cycle memory, continuous consumption
    lat = 1; p_ird = 100;
    repeat (20) step();
    check("t2_first_addr", qget(acc_addr, 0), 32'h0);
    check("t2_pop_count", pop_pc.size(), 17);
    for (int i = 0; i < 8; i++) check($sformatf("t2_pc%0d", i), qget(pop_pc, i), 32'(4 * i));

    // 3: consumer stalled -> credit limit
    do_reset();
    p_ird = 0;
    repeat (12) step();
    check("t3_req_count", acc_addr.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_addr%0d", i), qget(acc_addr, i), 32'(4 * i));
    #2;
    check("t3_req_valid_low", bus.imem_req_valid, 1'b0);
    check("t3_full_count", bus.queue_count, 4);
    p_ird = 100;
    repeat (6) step();
    check("t3_resume_addr", qget(acc_addr, 4), 32'h10);

    // 4: redirect with two responses in flight, 3-cycle memory
    do_reset();
    lat = 3; p_ird = 100;
    for (k = 0; k < 30 && m_iss.size() < 2; k++) step();
    check("t4_two_outstanding", m_iss.size(), 2);
    n = acc_addr.size();
    rc = cyc;
    do_redir = 1'b1; redir_target = 32'h0000_0103;
    step();
    repeat (12) step();
    check("t4_next_addr", qget(acc_addr, n), 32'h100);
    check("t4_next_cycle", (n < acc_cyc.size()) ? acc_cyc[n] : -1, rc + 3);
    check("t4_first_pc", qget(pop_pc, 0), 32'h100);

    // 5: redirect coinciding with a response and a pop
    do_reset();
    lat = 2; p_ird = 0;
    for (k = 0; k < 30 && !(m_fifo.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc); k++) step();
    check("t5_setup", (m_fifo.size() > 0) && (mem_q.size() > 0), 1'b1);
    n = pop_pc.size();
    p_ird = 100;
    do_redir = 1'b1; redir_target = 32'h0000_0200;
    step();
    #2;
    check("t5_instr_valid", bus.instr_valid, 1'b0);
    check("t5_queue_count", bus.queue_count, 0);
    repeat (12) step();
    check("t5_first_pc", qget(pop_pc, n), 32'h200);

    // 6: address wrap after redirect near the top of memory
    do_reset();
    lat = 1; p_ird = 100;
    repeat (4) step();
    do_redir = 1'b1; redir_target = 32'hFFFF_FFF8;
    step();
    n = acc_addr.size();
    repeat (10) step();
    check("t6_addr0", qget(acc_addr, n),     32'hFFFF_FFF8);
    check("t6_addr1", qget(acc_addr, n + 1), 32'hFFFF_FFFC);
    check("t6_addr2", qget(acc_addr, n + 2), 32'h0000_0000);

    // 7: random traffic against the model
    do_reset();
    p_rdy = 70; p_ird = 60; p_redir = 4; p_rsp = 70; lat = 0;
    repeat (2000) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
